// File: rtl/general_demux_stream_if.sv
// Handshake bundle for the 1-to-N stream demux: one input stream fanned out to
// NUM_OUTPUTS single-slot lanes, with an error pulse and a drop counter.
interface general_demux_stream_if #(
  parameter int NUM_OUTPUTS = 5,
  parameter int WIDTH       = 4
);
  localparam int SEL_W = $clog2(NUM_OUTPUTS);

  logic [WIDTH-1:0]             in_data;
  logic [SEL_W-1:0]             in_sel;
  logic                         in_valid;
  logic                         in_ready;
  logic                         auto_mode;
  logic [NUM_OUTPUTS*WIDTH-1:0] out_data;
  logic [NUM_OUTPUTS-1:0]       out_valid;
  logic [NUM_OUTPUTS-1:0]       out_ready;
  logic                         err_sel;
  logic [7:0]                   err_cnt;

  modport master (
    output in_data, in_sel, in_valid, auto_mode, out_ready,
    input  in_ready, out_data, out_valid, err_sel, err_cnt
  );

  modport slave (
    input  in_data, in_sel, in_valid, auto_mode, out_ready,
    output in_ready, out_data, out_valid, err_sel, err_cnt
  );
endinterface

// File: rtl/general_demux_stream.sv
// 1-to-NUM_OUTPUTS stream demux: words go to an explicit lane or a round-robin
// lane, each lane owning a one-entry slot; out-of-range selects are dropped.
module general_demux_stream_lane #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Fill wins over drain so a same-cycle drain+fill keeps the slot full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && ready) valid_d = 1'b0;
    if (fill) begin
      valid_d = 1'b1;
      data_d  = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
endmodule

module general_demux_stream #(
  parameter int NUM_OUTPUTS = 5,
  parameter int WIDTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  general_demux_stream_if.slave  bus
);
  localparam int SEL_W = $clog2(NUM_OUTPUTS);
  localparam int SW1   = SEL_W + 1;
  localparam logic [SEL_W:0]   NUM_O = SW1'(NUM_OUTPUTS);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(NUM_OUTPUTS - 1);

  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             err_sel_q, err_sel_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic [SEL_W-1:0]                  tgt;
  logic                              in_range;
  logic                              in_ready;
  logic                              accept;
  logic [NUM_OUTPUTS-1:0]            tgt_oh;
  logic [NUM_OUTPUTS-1:0]            lane_free;
  logic [NUM_OUTPUTS-1:0]            fill;
  logic [NUM_OUTPUTS-1:0]            lane_valid;
  logic [NUM_OUTPUTS-1:0][WIDTH-1:0] lane_data;

  always_comb begin
    tgt      = bus.auto_mode ? rr_ptr_q : bus.in_sel;
    // Extra MSB keeps the compare unsigned and exact for power-of-two lane counts.
    in_range = {1'b0, tgt} < NUM_O;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      tgt_oh[k]    = in_range && (tgt == SEL_W'(k));
      lane_free[k] = ~lane_valid[k] | bus.out_ready[k];
    end
    // Dropped words never stall the input.
    in_ready = ~in_range | (|(tgt_oh & lane_free));
    accept   = bus.in_valid & in_ready;
    fill     = accept ? tgt_oh : '0;

    rr_ptr_d = rr_ptr_q;
    if (accept && bus.auto_mode)
      rr_ptr_d = (rr_ptr_q == LAST) ? '0 : rr_ptr_q + 1'b1;

    err_sel_d = accept & ~in_range;
    err_cnt_d = err_cnt_q;
    if (err_sel_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      err_sel_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      err_sel_q <= err_sel_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_lane
    general_demux_stream_lane #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .fill  (fill[k]),
      .wdata (bus.in_data),
      .ready (bus.out_ready[k]),
      .valid (lane_valid[k]),
      .data  (lane_data[k])
    );
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = lane_data;
  assign bus.out_valid = lane_valid;
  assign bus.err_sel   = err_sel_q;
  assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_general_demux_stream.sv
// Bench for general_demux_stream: directed scenario tasks plus a negedge
// scoreboard that tracks per-lane expected words, rr pointer and drop count.
module tb_general_demux_stream;
  localparam int N = 5;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  general_demux_stream_if #(.NUM_OUTPUTS(N), .WIDTH(W)) bus ();
  general_demux_stream #(.NUM_OUTPUTS(N), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_pass = 0;
  int n_total = 0;

  logic [W-1:0] sb_q [N][$];
  int   rr_m = 0;
  int   err_cnt_m = 0;
  bit   err_sel_m = 0;
  bit   mon_en = 0;

  function automatic logic [W-1:0] lane(int k);
    return bus.out_data[k*W +: W];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: checks the DUT state left by the previous edge, then records
  // what the coming edge will accept, drain or drop.
  int t;
  bit inr, rdy, expv;
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) sb_q[k].delete();
      rr_m = 0; err_cnt_m = 0; err_sel_m = 0; mon_en = 1;
    end else if (mon_en) begin
      t   = bus.auto_mode ? rr_m : int'(bus.in_sel);
      inr = t < N;
      rdy = !inr || (sb_q[t].size() == 0) || bus.out_ready[t];
      n_total++;
      if (bus.in_ready !== rdy) $display("FAIL sb_in_ready t=%0t got %b exp %b", $time, bus.in_ready, rdy);
      else n_pass++;
      n_total++;
      if (bus.err_sel !== err_sel_m) $display("FAIL sb_err_sel t=%0t got %b exp %b", $time, bus.err_sel, err_sel_m);
      else n_pass++;
      n_total++;
      if (bus.err_cnt !== 8'(err_cnt_m)) $display("FAIL sb_err_cnt t=%0t got %0d exp %0d", $time, bus.err_cnt, err_cnt_m);
      else n_pass++;
      for (int k = 0; k < N; k++) begin
        expv = sb_q[k].size() != 0;
        n_total++;
        if (bus.out_valid[k] !== expv) $display("FAIL sb_valid lane%0d t=%0t got %b exp %b", k, $time, bus.out_valid[k], expv);
        else n_pass++;
        if (expv && bus.out_ready[k]) begin
          n_total++;
          if (lane(k) !== sb_q[k][0]) $display("FAIL sb_data lane%0d t=%0t got %h exp %h", k, $time, lane(k), sb_q[k][0]);
          else n_pass++;
          void'(sb_q[k].pop_front());
        end
      end
      err_sel_m = 0;
      if (bus.in_valid && rdy) begin
        if (inr) sb_q[t].push_back(bus.in_data);
        else begin
          err_sel_m = 1;
          if (err_cnt_m != 255) err_cnt_m++;
        end
        if (bus.auto_mode) rr_m = (rr_m == N-1) ? 0 : rr_m + 1;
      end
    end
  end

  task automatic test_reset();
    rst = 1; bus.in_valid = 1; bus.in_data = 4'($urandom); bus.in_sel = 0;
    bus.auto_mode = 0; bus.out_ready = '0;
    step(); bus.in_data = 4'($urandom); step();
    rst = 0; bus.in_valid = 0;
    n_total++;
    if (bus.out_valid !== 5'b00000) $display("FAIL rst_valid got %b exp 00000", bus.out_valid); else n_pass++;
    n_total++;
    if (bus.out_data !== '0) $display("FAIL rst_data got %h exp 0", bus.out_data); else n_pass++;
    n_total++;
    if (bus.err_cnt !== 8'd0) $display("FAIL rst_err_cnt got %0d exp 0", bus.err_cnt); else n_pass++;
    n_total++;
    if (bus.err_sel !== 1'b0) $display("FAIL rst_err_sel got %b exp 0", bus.err_sel); else n_pass++;
    // rr_ptr=0 shows up as the first auto word landing in lane 0
    bus.auto_mode = 1; bus.out_ready = '1; bus.in_valid = 1; bus.in_data = 4'h9;
    step(); bus.in_valid = 0;
    n_total++;
    if (bus.out_valid !== 5'b00001 || lane(0) !== 4'h9)
      $display("FAIL rst_rr_ptr got valid %b data %h exp 00001 9", bus.out_valid, lane(0));
    else n_pass++;
    step();
  endtask

  task automatic test_manual();
    bus.auto_mode = 0; bus.out_ready = '1;
    for (int k = 0; k < N; k++) begin
      bus.in_sel = 3'(k); bus.in_data = 4'(k + 1); bus.in_valid = 1;
      #1;
      n_total++;
      if (bus.in_ready !== 1'b1) $display("FAIL man_in_ready lane%0d got %b exp 1", k, bus.in_ready); else n_pass++;
      step();
      n_total++;
      if (bus.out_valid !== 5'(1 << k) || lane(k) !== 4'(k + 1))
        $display("FAIL man_route lane%0d got %b/%h exp %b/%h", k, bus.out_valid, lane(k), 5'(1 << k), 4'(k + 1));
      else n_pass++;
    end
    bus.in_valid = 0;
    step();
    n_total++;
    if (bus.out_valid !== 5'b00000) $display("FAIL man_idle got %b exp 00000", bus.out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    bus.auto_mode = 0; bus.out_ready = 5'b11011; bus.in_sel = 2;
    bus.in_data = 4'hA; bus.in_valid = 1;
    step();
    bus.in_data = 4'hB;
    #1;
    n_total++;
    if (bus.out_valid[2] !== 1'b1 || lane(2) !== 4'hA) $display("FAIL bp_hold got %b/%h exp 1/a", bus.out_valid[2], lane(2)); else n_pass++;
    n_total++;
    if (bus.in_ready !== 1'b0) $display("FAIL bp_stall got %b exp 0", bus.in_ready); else n_pass++;
    step();
    n_total++;
    if (bus.out_valid[2] !== 1'b1 || lane(2) !== 4'hA) $display("FAIL bp_stable got %b/%h exp 1/a", bus.out_valid[2], lane(2)); else n_pass++;
    bus.out_ready = '1;
    #1;
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL bp_release got %b exp 1", bus.in_ready); else n_pass++;
    step();
    bus.in_valid = 0;
    n_total++;
    if (bus.out_valid[2] !== 1'b1 || lane(2) !== 4'hB) $display("FAIL bp_drain_fill got %b/%h exp 1/b", bus.out_valid[2], lane(2)); else n_pass++;
    step();
    n_total++;
    if (bus.out_valid[2] !== 1'b0 || lane(2) !== 4'hB) $display("FAIL bp_retain got %b/%h exp 0/b", bus.out_valid[2], lane(2)); else n_pass++;
  endtask

  task automatic test_out_of_range();
    bus.auto_mode = 0; bus.out_ready = '1; bus.in_data = 4'hF; bus.in_valid = 1;
    for (int i = 0; i < 300; i++) begin
      bus.in_sel = (i % 2) ? 3'd7 : 3'd6;
      #1;
      n_total++;
      if (bus.in_ready !== 1'b1) $display("FAIL oor_ready i=%0d got %b exp 1", i, bus.in_ready); else n_pass++;
      step();
      n_total++;
      if (bus.err_sel !== 1'b1 || bus.out_valid !== 5'b00000)
        $display("FAIL oor_pulse i=%0d got %b/%b exp 1/00000", i, bus.err_sel, bus.out_valid);
      else n_pass++;
      if (i == 9) begin
        n_total++;
        if (bus.err_cnt !== 8'd10) $display("FAIL oor_count got %0d exp 10", bus.err_cnt); else n_pass++;
      end
    end
    bus.in_valid = 0;
    step();
    n_total++;
    if (bus.err_sel !== 1'b0) $display("FAIL oor_pulse_end got %b exp 0", bus.err_sel); else n_pass++;
    n_total++;
    if (bus.err_cnt !== 8'd255) $display("FAIL oor_saturate got %0d exp 255", bus.err_cnt); else n_pass++;
  endtask

  task automatic test_round_robin();
    rst = 1; step(); rst = 0;
    bus.auto_mode = 0; bus.out_ready = 5'b10111; bus.in_sel = 3; bus.in_data = 4'h9; bus.in_valid = 1;
    step();
    bus.auto_mode = 1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 4'(i + 1);
      #1;
      n_total++;
      if (bus.in_ready !== (i < 3)) $display("FAIL rr_ready i=%0d got %b exp %b", i, bus.in_ready, (i < 3)); else n_pass++;
      step();
      if (i < 3) begin
        n_total++;
        if (bus.out_valid[i] !== 1'b1 || lane(i) !== 4'(i + 1))
          $display("FAIL rr_order i=%0d got %b/%h exp 1/%h", i, bus.out_valid[i], lane(i), 4'(i + 1));
        else n_pass++;
      end
    end
    bus.in_data = 4'hE;
    step();
    n_total++;
    if (bus.in_ready !== 1'b0 || lane(3) !== 4'h9 || bus.out_valid[3] !== 1'b1)
      $display("FAIL rr_stall got %b/%h/%b exp 0/9/1", bus.in_ready, lane(3), bus.out_valid[3]);
    else n_pass++;
    bus.in_data = 4'h4; bus.out_ready = '1;
    #1;
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL rr_release got %b exp 1", bus.in_ready); else n_pass++;
    step();
    n_total++;
    if (bus.out_valid !== 5'b01000 || lane(3) !== 4'h4) $display("FAIL rr_lane3 got %b/%h exp 01000/4", bus.out_valid, lane(3)); else n_pass++;
    bus.in_data = 4'h5;
    step();
    n_total++;
    if (bus.out_valid !== 5'b10000 || lane(4) !== 4'h5) $display("FAIL rr_lane4 got %b/%h exp 10000/5", bus.out_valid, lane(4)); else n_pass++;
    bus.in_data = 4'h6;
    step();
    n_total++;
    if (bus.out_valid !== 5'b00001 || lane(0) !== 4'h6) $display("FAIL rr_wrap got %b/%h exp 00001/6", bus.out_valid, lane(0)); else n_pass++;
    bus.in_valid = 0;
    step();
  endtask

  task automatic test_mid_reset();
    bus.auto_mode = 0; bus.out_ready = 5'b01101; bus.in_valid = 1;
    bus.in_sel = 1; bus.in_data = 4'h7; step();
    bus.in_sel = 4; bus.in_data = 4'h8; step();
    bus.in_valid = 0;
    n_total++;
    if (bus.out_valid !== 5'b10010) $display("FAIL mr_full got %b exp 10010", bus.out_valid); else n_pass++;
    rst = 1; bus.auto_mode = 1; bus.in_valid = 1; bus.in_data = 4'h3;
    step();
    rst = 0; bus.out_ready = '1;
    n_total++;
    if (bus.out_valid !== 5'b00000 || bus.err_sel !== 1'b0) $display("FAIL mr_clear got %b/%b exp 00000/0", bus.out_valid, bus.err_sel); else n_pass++;
    step();
    bus.in_valid = 0;
    n_total++;
    if (bus.out_valid !== 5'b00001 || lane(0) !== 4'h3) $display("FAIL mr_rr0 got %b/%h exp 00001/3", bus.out_valid, lane(0)); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    bus.auto_mode = 1; bus.out_ready = '1; bus.in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      bus.in_data = 4'(i * 7 + 3);
      #1;
      n_total++;
      if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready i=%0d got %b exp 1", i, bus.in_ready); else n_pass++;
      step();
    end
    bus.in_valid = 0;
    step();
  endtask

  task automatic test_random();
    int left;
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 3) != 0);
      bus.in_data   = 4'($urandom);
      bus.in_sel    = 3'($urandom_range(0, 7));
      bus.auto_mode = 1'($urandom);
      bus.out_ready = 5'($urandom);
      step();
    end
    bus.in_valid = 0; bus.out_ready = '1;
    step(); step(); step();
    left = 0;
    for (int k = 0; k < N; k++) left += sb_q[k].size();
    n_total++;
    if (left != 0 || bus.out_valid !== 5'b00000) $display("FAIL rnd_drain got %0d/%b exp 0/00000", left, bus.out_valid); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1; bus.in_valid = 0; bus.in_data = '0; bus.in_sel = '0;
    bus.auto_mode = 0; bus.out_ready = '0;
    test_reset();
    test_manual();
    test_backpressure();
    test_out_of_range();
    test_round_robin();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/general_demux_stream.md
Name: general_demux_stream

Overview:
- 1-to-NUM_OUTPUTS stream demultiplexer with a parameterised number of outputs and parameterised word width; it is the distribution counterpart of the general mux.
- Accepts one word per cycle on a valid/ready input and routes it to one output lane.
- Each lane has a one-entry registered slot with its own valid/ready handshake.
- The target lane comes from an explicit select or from an internal round-robin pointer; out-of-range selects are dropped and counted.

Parameters:
- NUM_OUTPUTS, 5, number of output lanes (must be >= 2).
- WIDTH, 4, bits per word.
- SEL_W, $clog2(NUM_OUTPUTS), localparam; width of select and round-robin pointer.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  input word.
- in_sel  input  SEL_W  target lane in manual mode.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept in_data this cycle (combinational).
- auto_mode  input  1  1 = round-robin target, in_sel ignored; 0 = in_sel target.
- out_data  output  NUM_OUTPUTS*WIDTH  lane k word at [k*WIDTH +: WIDTH] (same packing as the mux input bus).
- out_valid  output  NUM_OUTPUTS  per-lane slot full.
- out_ready  input  NUM_OUTPUTS  per-lane consumer ready.
- err_sel  output  1  one-cycle pulse: out-of-range word dropped.
- err_cnt  output  8  saturating count of dropped words.

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_data=0, rr_ptr=0, err_sel=0, err_cnt=0. Any pending words are discarded, including when reset arrives mid-stream. in_ready is driven purely combinationally from state and inputs.
- Target: tgt = auto_mode ? rr_ptr : in_sel, evaluated combinationally each cycle. A change of auto_mode takes effect the same cycle. rr_ptr is retained across mode changes.
- Range: in manual mode, in_sel >= NUM_OUTPUTS is out of range. rr_ptr is never out of range.
- Per-lane slot states:
  - EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
  - drain_k = out_valid[k] & out_ready[k].
  - EMPTY -> FULL on fill.
  - FULL -> EMPTY on drain without fill.
  - FULL stays FULL on drain and fill in the same cycle; out_data lane k takes the new word.
- in_ready:
  - In-range target: in_ready = ~out_valid[tgt] | out_ready[tgt].
  - Out-of-range target: in_ready = 1.
- Accept = in_valid & in_ready.
  - In range: the word is written to lane tgt. out_valid[tgt] is 1 the next cycle (latency 1 cycle).
  - Out of range: the word is consumed and dropped. err_sel=1 the next cycle only. err_cnt increments and holds at 255. No lane changes.
- Lane stability: while out_valid[k]=1 and out_ready[k]=0, lane k data and valid hold stable.
- Lane isolation: lanes not targeted are unaffected except by their own drain.
- After a drain, lane data retains its last value with valid=0.
- in_data changes while in_ready=0 are ignored; there is no buffering beyond the per-lane slots.
- Round robin: rr_ptr advances only on an accepted word in auto mode, wrapping NUM_OUTPUTS-1 -> 0. A stall (in_ready=0) leaves rr_ptr unchanged; the block never skips to a free lane (strict order).
- Throughput: 1 word/cycle sustained when the consumers hold out_ready high.
- Width rule: in_sel is compared as unsigned against NUM_OUTPUTS. For power-of-two NUM_OUTPUTS, no select is out of range and err_cnt stays 0.

Test Plan:
1. Reset check: hold rst=1 for 2 cycles with in_valid=1 and random data -> out_valid=5'b00000, out_data=0, err_cnt=0, rr_ptr=0 after release.
2. Manual routing: out_ready=all 1; send in_sel=0..4 with data 4'h1..4'h5 on consecutive cycles -> each lane k gets valid for one cycle, one cycle after its send, with data k+1; in_ready stays 1 throughout.
3. Backpressure: out_ready[2]=0; send two words (4'hA, then 4'hB) to lane 2 -> first sits in lane 2 with valid=1, in_ready=0 on the second; raise out_ready[2] -> same-cycle drain+fill, lane 2 shows 4'hB the next cycle with no valid gap.
4. Out-of-range: manual, in_sel=6 and 7, data 4'hF, 300 times -> in_ready=1, no lane valid, err_sel pulses each following cycle, err_cnt saturates at 255.
5. Round robin with stall: auto_mode=1, lane 3 out_ready=0 and full; send 4 words -> lanes 0,1,2 filled, then in_ready=0 at rr_ptr=3; release lane 3 -> word goes to lane 3, then lane 4, then wrap to lane 0.
6. Mid-operation reset: lanes 1 and 4 full under backpressure, assert rst one cycle -> all out_valid=0 the next cycle, rr_ptr=0, next auto-mode word lands in lane 0.
